// File: rtl/pcie_led_pkg.sv
// Shared types and LED bit map for the PCIe link status/LED block.
// Used by pcie_link_led_ctrl and anything decoding its LED bus.
package pcie_led_pkg;

  typedef enum logic [1:0] {
    S_PERST = 2'd0,
    S_WAIT  = 2'd1,
    S_DEB   = 2'd2,
    S_UP    = 2'd3
  } state_e;

  localparam int unsigned LED_HB      = 0;
  localparam int unsigned LED_LINK    = 1;
  localparam int unsigned LED_PERST   = 2;
  localparam int unsigned LED_DEB     = 3;
  localparam int unsigned LED_CNT_LSB = 4;

endpackage

// File: rtl/ms_tick_gen.sv
// Free-running divider producing a 1-cycle tick every TICK_DIV clocks.
// Shared time base for all millisecond timing in the LED block.
module ms_tick_gen #(
  parameter int unsigned TICK_DIV = 250000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CW =
    (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick = (cnt_q == LAST);

  // Wrap to zero on the tick cycle, otherwise count up.
  always_comb begin
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  // Divider counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/pcie_link_led_ctrl.sv
// PCIe link status stage: sync, debounce, drop counter, board LEDs.
// Optional PERST-to-link timeout blink: define PCIE_LED_TIMEOUT_EN.
module pcie_link_led_ctrl #(
  parameter int unsigned TICK_DIV     = 250000,
  parameter int unsigned DEBOUNCE_MS  = 10,
  parameter int unsigned HEARTBEAT_MS = 500,
  parameter int unsigned TIMEOUT_MS   = 1000,
  parameter int unsigned DROP_CNT_W   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pcie_perst_n,
  input  logic                  pcie_link_up,
  input  logic                  clr_cnt,
  output logic                  link_stable,
  output logic [DROP_CNT_W-1:0] link_drop_cnt,
  output logic [7:0]            LED
);

  import pcie_led_pkg::*;

  localparam int unsigned DW = $clog2(DEBOUNCE_MS + 1);
  localparam logic [DW-1:0] DEB_DONE = DW'(DEBOUNCE_MS);
  localparam int unsigned HW =
    (HEARTBEAT_MS > 1) ? $clog2(HEARTBEAT_MS) : 1;
  localparam logic [HW-1:0] HB_LAST = HW'(HEARTBEAT_MS - 1);

  logic perst_m_q, perst_s_q;
  logic link_m_q, link_s_q;
  logic tick;

  state_e                  state_q, state_d;
  logic [DW-1:0]           deb_q, deb_d;
  logic [DROP_CNT_W-1:0]   drop_q, drop_d;
  logic                    drop_inc;
  logic                    stable_q;
  logic [HW-1:0]           hb_cnt_q, hb_cnt_d;
  logic                    hb_q, hb_d;
  logic                    deb_led;
  logic [7:0]              led_q, led_d;

  assign link_stable   = stable_q;
  assign link_drop_cnt = drop_q;
  assign LED           = led_q;

  // Two-flop synchronisers for the asynchronous PCIe status pins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perst_m_q <= 1'b0;
      perst_s_q <= 1'b0;
      link_m_q  <= 1'b0;
      link_s_q  <= 1'b0;
    end else begin
      perst_m_q <= pcie_perst_n;
      perst_s_q <= perst_m_q;
      link_m_q  <= pcie_link_up;
      link_s_q  <= link_m_q;
    end
  end

  ms_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Link FSM next state; PERST overrides everything.
  always_comb begin
    state_d = state_q;
    deb_d   = deb_q;
    if (!perst_s_q) begin
      state_d = S_PERST;
      deb_d   = '0;
    end else begin
      unique case (state_q)
        S_PERST: state_d = S_WAIT;
        S_WAIT: begin
          if (link_s_q) begin
            state_d = S_DEB;
            deb_d   = '0;
          end
        end
        S_DEB: begin
          if (!link_s_q) begin
            state_d = S_WAIT;
          end else if (tick) begin
            deb_d = deb_q + 1'b1;
            if (deb_d == DEB_DONE) state_d = S_UP;
          end
        end
        S_UP: begin
          if (!link_s_q) state_d = S_WAIT;
        end
        default: state_d = S_PERST;
      endcase
    end
  end

  // Drop counter: saturating, clear beats a same-cycle increment.
  always_comb begin
    drop_inc = (state_q == S_UP) && (state_d == S_WAIT);
    drop_d   = drop_q;
    if (clr_cnt)
      drop_d = '0;
    else if (drop_inc && (drop_q != '1))
      drop_d = drop_q + 1'b1;
  end

  // Heartbeat phase toggles every HEARTBEAT_MS ticks.
  always_comb begin
    hb_cnt_d = hb_cnt_q;
    hb_d     = hb_q;
    if (tick) begin
      if (hb_cnt_q == HB_LAST) begin
        hb_cnt_d = '0;
        hb_d     = ~hb_q;
      end else begin
        hb_cnt_d = hb_cnt_q + 1'b1;
      end
    end
  end

`ifdef PCIE_LED_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_MS + 1);
  localparam logic [TW-1:0] TO_LIMIT = TW'(TIMEOUT_MS);

  logic [TW-1:0] to_q, to_d;
  logic          to_flag_q, to_flag_d;

  // Count ticks spent waiting for link after PERST release.
  always_comb begin
    to_d      = to_q;
    to_flag_d = to_flag_q;
    if (state_q == S_PERST && state_d == S_WAIT)
      to_d = '0;
    else if (state_q == S_WAIT && tick && to_q != TO_LIMIT)
      to_d = to_q + 1'b1;
    if (state_d == S_UP || state_d == S_PERST)
      to_flag_d = 1'b0;
    else if (to_d == TO_LIMIT)
      to_flag_d = 1'b1;
  end

  // Timeout counter and sticky flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_q      <= '0;
      to_flag_q <= 1'b0;
    end else begin
      to_q      <= to_d;
      to_flag_q <= to_flag_d;
    end
  end

  assign deb_led = to_flag_d ? ~hb_d : (state_d == S_DEB);
`else
  assign deb_led = (state_d == S_DEB);
`endif

  // Assemble the LED pattern from next-state values.
  always_comb begin
    led_d = '0;
    led_d[LED_HB]    = hb_d;
    led_d[LED_LINK]  = (state_d == S_UP);
    led_d[LED_PERST] = perst_s_q;
    led_d[LED_DEB]   = deb_led;
    led_d[LED_CNT_LSB +: 4] = drop_d[3:0];
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_PERST;
      deb_q    <= '0;
      drop_q   <= '0;
      stable_q <= 1'b0;
      led_q    <= 8'h00;
    end else begin
      state_q  <= state_d;
      deb_q    <= deb_d;
      drop_q   <= drop_d;
      stable_q <= (state_d == S_UP);
      led_q    <= led_d;
    end
  end

  // Heartbeat divider state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hb_cnt_q <= '0;
      hb_q     <= 1'b0;
    end else begin
      hb_cnt_q <= hb_cnt_d;
      hb_q     <= hb_d;
    end
  end

endmodule

// File: tb/tb_pcie_link_led_ctrl.sv
// Directed bench for pcie_link_led_ctrl with small timing parameters.
// Define PCIE_LED_TIMEOUT_EN to also check the timeout blink.
module tb_pcie_link_led_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       perst_n;
  logic       link_up;
  logic       clr_cnt;
  logic       link_stable;
  logic [7:0] drop_cnt;
  logic [7:0] led;

  int   vectors = 0;
  int   miscompares = 0;
  int   n;
  logic seen;
  logic hi;
  logic to_en;

  always #5 clk = ~clk;

  pcie_link_led_ctrl #(
    .TICK_DIV     (4),
    .DEBOUNCE_MS  (3),
    .HEARTBEAT_MS (2),
    .TIMEOUT_MS   (5),
    .DROP_CNT_W   (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pcie_perst_n  (perst_n),
    .pcie_link_up  (link_up),
    .clr_cnt       (clr_cnt),
    .link_stable   (link_stable),
    .link_drop_cnt (drop_cnt),
    .LED           (led)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic wait_up(input string tag);
    n = 0;
    while (!link_stable && n < 40) begin
      cyc(1);
      n++;
    end
    chk(tag, 32'(link_stable), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef PCIE_LED_TIMEOUT_EN
    to_en = 1'b1;
`else
    to_en = 1'b0;
`endif
    rst = 1'b1;
    perst_n = 1'b1;
    link_up = 1'b1;
    clr_cnt = 1'b0;
    cyc(3);
    chk("rst_led", 32'(led), 32'h00);
    chk("rst_stable", 32'(link_stable), 32'd0);
    chk("rst_cnt", 32'(drop_cnt), 32'd0);

    // bring-up: PERST -> WAIT -> DEB -> UP
    rst = 1'b0;
    n = 0;
    while (!led[3] && n < 10) begin
      cyc(1);
      n++;
    end
    chk("deb_entry_clk", 32'(n), 32'd4);
    n = 0;
    while (!link_stable && n < 16) begin
      cyc(1);
      n++;
    end
    chk("deb_to_up_clk", 32'(n), 32'd12);
    chk("up_led_321", 32'(led[3:1]), 32'h3);

    // link drop: 3 clk latency, counted
    link_up = 1'b0;
    cyc(2);
    chk("drop_lat2", 32'(link_stable), 32'd1);
    cyc(1);
    chk("drop_lat3", 32'(link_stable), 32'd0);
    chk("drop_cnt1", 32'(drop_cnt), 32'd1);
    chk("drop_nib1", 32'(led[7:4]), 32'h1);

    // glitch shorter than debounce
    seen = 1'b0;
    hi = 1'b0;
    link_up = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      seen |= led[3];
      hi |= link_stable;
    end
    link_up = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      hi |= link_stable;
    end
    chk("glitch_deb_seen", 32'(seen), 32'd1);
    chk("glitch_deb_clr", 32'(led[3]), 32'd0);
    chk("glitch_stable", 32'(hi), 32'd0);
    chk("glitch_cnt", 32'(drop_cnt), 32'd1);

    // PERST while up: not a drop
    link_up = 1'b1;
    wait_up("perst_pre_up");
    perst_n = 1'b0;
    cyc(2);
    chk("perst_lat2", 32'(link_stable), 32'd1);
    cyc(1);
    chk("perst_lat3", 32'(link_stable), 32'd0);
    chk("perst_led2", 32'(led[2]), 32'd0);
    chk("perst_cnt", 32'(drop_cnt), 32'd1);
    perst_n = 1'b1;
    wait_up("perst_rel_up");

    // clear in the same cycle as a drop increment
    link_up = 1'b0;
    cyc(2);
    clr_cnt = 1'b1;
    cyc(1);
    clr_cnt = 1'b0;
    chk("clr_race_stable", 32'(link_stable), 32'd0);
    chk("clr_race_cnt", 32'(drop_cnt), 32'd0);

    // 300 drops saturate the counter
    for (int i = 0; i < 300; i++) begin
      link_up = 1'b1;
      n = 0;
      while (!link_stable && n < 40) begin
        cyc(1);
        n++;
      end
      if (!link_stable) begin
        chk("sat_up_timeout", 32'(link_stable), 32'd1);
        break;
      end
      link_up = 1'b0;
      n = 0;
      while (link_stable && n < 10) begin
        cyc(1);
        n++;
      end
      if (link_stable) begin
        chk("sat_dn_timeout", 32'(link_stable), 32'd0);
        break;
      end
      if (i == 15) begin
        chk("sat_cnt16", 32'(drop_cnt), 32'd16);
        chk("sat_nib16", 32'(led[7:4]), 32'h0);
      end
    end
    chk("sat_cnt", 32'(drop_cnt), 32'hFF);
    chk("sat_nib", 32'(led[7:4]), 32'hF);

    // asynchronous reset mid-operation
    link_up = 1'b1;
    wait_up("async_pre_up");
    #2 rst = 1'b1;
    #1;
    chk("async_led", 32'(led), 32'h00);
    chk("async_stable", 32'(link_stable), 32'd0);
    chk("async_cnt", 32'(drop_cnt), 32'd0);
    cyc(2);

    // heartbeat, link held low after PERST release
    link_up = 1'b0;
    rst = 1'b0;
    cyc(7);
    chk("hb_7", 32'(led[0]), 32'd0);
    cyc(1);
    chk("hb_8", 32'(led[0]), 32'd1);
    cyc(7);
    chk("hb_15", 32'(led[0]), 32'd1);
    cyc(1);
    chk("hb_16", 32'(led[0]), 32'd0);
    cyc(3);
    chk("to_19", 32'(led[3]), 32'd0);
    cyc(1);
    chk("to_20", 32'(led[3]), 32'(to_en));
    chk("to_20_perst", 32'(led[2]), 32'd1);
    cyc(4);
    chk("hb_24", 32'(led[0]), 32'd1);
    chk("to_24", 32'(led[3]), 32'd0);
    cyc(8);
    chk("hb_32", 32'(led[0]), 32'd0);
    chk("to_32", 32'(led[3]), 32'(to_en));

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
